// File: rtl/axis_uart_pkg.sv
// Shared types and constants for the AXI4-Stream UART transmitter.
// Holds the FSM state encoding, parity selectors, line-terminator bytes and frame sizing helper.
package axis_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_EOL
  } state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [7:0] EOL_CR = 8'h0D;
  localparam logic [7:0] EOL_LF = 8'h0A;

  // Bit periods per frame: start + 8 data + optional parity + stop bits.
  function automatic int frame_bits(input int parity, input int stop_bits);
    return 9 + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/axis_uart_tx_if.sv
// AXI4-Stream byte channel into the UART transmitter.
// Handshake: a byte transfers on a rising clock edge where i_tvalid and o_tready are both high; the producer holds i_tdata/i_tlast stable while i_tvalid is high and o_tready is low.
interface axis_uart_tx_if;
  logic [7:0] i_tdata;
  logic       i_tlast;
  logic       i_tvalid;
  logic       o_tready;

  modport slave (
    input  i_tdata,
    input  i_tlast,
    input  i_tvalid,
    output o_tready
  );

  modport master (
    output i_tdata,
    output i_tlast,
    output i_tvalid,
    input  o_tready
  );
endinterface

// File: rtl/axis_uart_fifo.sv
// Synchronous FIFO with registered read data and occupancy count.
// A pop loads o_rdata on the same edge, so the word is usable the following cycle.
module axis_uart_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rdata_q;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = i_push & !o_full;
    pop_ok   = i_pop & !o_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (pop_ok) rdata_q <= mem_q[rd_ptr_q];
    end
  end

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_level = count_q;
  assign o_rdata = rdata_q;

endmodule

// File: rtl/axis_uart_tx.sv
// AXI4-Stream to UART transmitter: FIFO-buffered bytes serialised with configurable baud, parity and stop bits.
// Define AXIS_UART_TX_EOL_EN to append CR/LF frames after every byte that was pushed with tlast set.
module axis_uart_tx
  import axis_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  axis_uart_tx_if.slave               s_axis,
  output logic                        o_uart_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output state_e                      o_state
);
  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int BW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] DIV_M1 = BW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("axis_uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("axis_uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_frame_chk
    $error("axis_uart_tx: PARITY must be 0..2 and STOP_BITS 1..2");
  end

  logic [8:0]              fifo_rdata;
  logic                    fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                    tready, push, pop;
  logic                    bit_end, last_stop;
  logic [7:0]              frame_byte;

  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic          stop_idx_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          tx_q;

`ifdef AXIS_UART_TX_EOL_EN
  logic [1:0] eol_cnt_q;
  logic       from_eol_q;
  logic       eol_due;
  assign eol_due = (eol_cnt_q != 2'd0);
`else
  logic unused_tlast;
  assign unused_tlast = fifo_rdata[8];
`endif

  assign tready          = !fifo_full & !i_rst;
  assign s_axis.o_tready = tready;
  assign push            = s_axis.i_tvalid & tready;

  axis_uart_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata ({s_axis.i_tlast, s_axis.i_tdata}),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level)
  );

  // The STOP exit pops directly into the next frame so back-to-back bytes have no idle gap.
  always_comb begin
    bit_end   = (baud_q == '0);
    last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
    pop       = 1'b0;
    if (!fifo_empty) begin
      if (state_q == ST_IDLE) pop = 1'b1;
`ifdef AXIS_UART_TX_EOL_EN
      if ((state_q == ST_STOP) && bit_end && last_stop && !eol_due) pop = 1'b1;
`else
      if ((state_q == ST_STOP) && bit_end && last_stop) pop = 1'b1;
`endif
    end
    frame_byte = fifo_rdata[7:0];
`ifdef AXIS_UART_TX_EOL_EN
    if (from_eol_q) frame_byte = shift_q;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= DIV_M1;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
`ifdef AXIS_UART_TX_EOL_EN
      eol_cnt_q  <= '0;
      from_eol_q <= 1'b0;
`endif
    end else begin
      if ((state_q == ST_IDLE) || (state_q == ST_EOL) || bit_end) baud_q <= DIV_M1;
      else baud_q <= baud_q - BW'(1);
`ifdef AXIS_UART_TX_EOL_EN
      if (pop) from_eol_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (pop) state_q <= ST_START;
        end
        ST_START: begin
          tx_q <= 1'b0;
          if (bit_end) begin
            state_q   <= ST_DATA;
            bit_idx_q <= '0;
            shift_q   <= frame_byte;
            par_q     <= ^frame_byte;
`ifdef AXIS_UART_TX_EOL_EN
            if (!from_eol_q && fifo_rdata[8]) eol_cnt_q <= 2'd2;
`endif
          end
        end
        ST_DATA: begin
          tx_q <= shift_q[0];
          if (bit_end) begin
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q    <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
              stop_idx_q <= 1'b0;
            end
          end
        end
        ST_PARITY: begin
          tx_q <= (PARITY == PARITY_EVEN) ? par_q : ~par_q;
          if (bit_end) state_q <= ST_STOP;
        end
        ST_STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            if (!last_stop) stop_idx_q <= stop_idx_q + 1'b1;
            else if (pop) state_q <= ST_START;
`ifdef AXIS_UART_TX_EOL_EN
            else if (eol_due) state_q <= ST_EOL;
`endif
            else state_q <= ST_IDLE;
          end
        end
`ifdef AXIS_UART_TX_EOL_EN
        ST_EOL: begin
          tx_q       <= 1'b1;
          shift_q    <= (eol_cnt_q == 2'd2) ? EOL_CR : EOL_LF;
          eol_cnt_q  <= eol_cnt_q - 2'd1;
          from_eol_q <= 1'b1;
          state_q    <= ST_START;
        end
`endif
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_uart_tx = tx_q;
  assign o_busy    = (state_q != ST_IDLE) | (fifo_level != '0);
  assign o_level   = fifo_level;
  assign o_state   = state_q;

endmodule

// File: tb/tb_axis_uart_tx.sv
// Directed bench for axis_uart_tx at DIV=4: exact line waveforms, parity, stop bits, back-pressure, tlast and reset.
module tb_axis_uart_tx;
  import axis_uart_pkg::*;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  axis_uart_tx_if a_if ();
  axis_uart_tx_if e_if ();
  axis_uart_tx_if o_if ();
  axis_uart_tx_if s_if ();

  logic a_tx, a_busy, e_tx, e_busy, o_tx, o_busy, s_tx, s_busy;
  logic [2:0] a_level, e_level, o_level, s_level;
  state_e a_state, e_state, o_state, s_state;

  axis_uart_tx #(.CLK_FREQ_HZ(16), .BAUD(4), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_a (
    .i_clk(clk), .i_rst(rst), .s_axis(a_if), .o_uart_tx(a_tx), .o_busy(a_busy), .o_level(a_level), .o_state(a_state));
  axis_uart_tx #(.CLK_FREQ_HZ(16), .BAUD(4), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) u_e (
    .i_clk(clk), .i_rst(rst), .s_axis(e_if), .o_uart_tx(e_tx), .o_busy(e_busy), .o_level(e_level), .o_state(e_state));
  axis_uart_tx #(.CLK_FREQ_HZ(16), .BAUD(4), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u_o (
    .i_clk(clk), .i_rst(rst), .s_axis(o_if), .o_uart_tx(o_tx), .o_busy(o_busy), .o_level(o_level), .o_state(o_state));
  axis_uart_tx #(.CLK_FREQ_HZ(16), .BAUD(4), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) u_s (
    .i_clk(clk), .i_rst(rst), .s_axis(s_if), .o_uart_tx(s_tx), .o_busy(s_busy), .o_level(s_level), .o_state(s_state));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level at bit period bp of a frame carrying byte d.
  function automatic logic exp_line(input logic [7:0] d, input int bp, input bit has_par, input logic pbit);
    if (bp == 0) return 1'b0;
    if (bp <= 8) return d[bp-1];
    if (has_par && (bp == 9)) return pbit;
    return 1'b1;
  endfunction

  // Receiver on the u_a line: returns the byte, a framing flag and a timeout flag.
  task automatic rx_byte(output logic [7:0] d, output bit framing_ok, output bit timed_out);
    int n = 0;
    d = '0;
    framing_ok = 1'b1;
    timed_out = 1'b0;
    while ((a_tx !== 1'b0) && (n < 200)) begin
      tick();
      n++;
    end
    if (a_tx !== 1'b0) begin
      timed_out = 1'b1;
      return;
    end
    tick(); tick();
    if (a_tx !== 1'b0) framing_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) tick();
      d[i] = a_tx;
    end
    repeat (DIV) tick();
    if (a_tx !== 1'b1) framing_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests_run++; if (a_tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b want 1", a_tx); end
    tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    tests_run++; if (a_level !== 3'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", a_level); end
    tests_run++; if (a_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", a_state, ST_IDLE); end
    tests_run++; if (a_if.o_tready !== 1'b0) begin tests_failed++; $display("FAIL reset_tready_low: got %b want 0", a_if.o_tready); end
    rst = 1'b0;
    tick();
    tests_run++; if (a_if.o_tready !== 1'b1) begin tests_failed++; $display("FAIL reset_tready_high: got %b want 1", a_if.o_tready); end
    tests_run++; if (s_if.o_tready !== 1'b1) begin tests_failed++; $display("FAIL reset_tready_s: got %b want 1", s_if.o_tready); end
  endtask

  task automatic test_single_byte();
    logic [7:0] d = 8'h55;
    int f = frame_bits(PARITY_NONE, 1) * DIV;
    a_if.i_tdata = d; a_if.i_tlast = 1'b0; a_if.i_tvalid = 1'b1;
    tick();
    a_if.i_tvalid = 1'b0;
    tests_run++; if (a_level !== 3'd1) begin tests_failed++; $display("FAIL single_level_push: got %0d want 1", a_level); end
    tick();
    tests_run++; if (a_state !== ST_START) begin tests_failed++; $display("FAIL single_state_start: got %0d want %0d", a_state, ST_START); end
    tests_run++; if (a_level !== 3'd0) begin tests_failed++; $display("FAIL single_level_pop: got %0d want 0", a_level); end
    tests_run++; if (a_tx !== 1'b1) begin tests_failed++; $display("FAIL single_tx_before_start: got %b want 1", a_tx); end
    tick();
    for (int k = 0; k < f; k++) begin
      tests_run++;
      if (a_tx !== exp_line(d, k / DIV, 1'b0, 1'b0)) begin
        tests_failed++; $display("FAIL single_line k=%0d: got %b want %b", k, a_tx, exp_line(d, k / DIV, 1'b0, 1'b0));
      end
      tests_run++;
      if (a_busy !== (k < f - 1)) begin
        tests_failed++; $display("FAIL single_busy k=%0d: got %b want %b", k, a_busy, (k < f - 1));
      end
      tick();
    end
    tests_run++; if (a_tx !== 1'b1) begin tests_failed++; $display("FAIL single_idle_line: got %b want 1", a_tx); end
  endtask

  task automatic test_parity();
    logic [7:0] d = 8'h07;
    int f = frame_bits(PARITY_EVEN, 1) * DIV;
    e_if.i_tdata = d; e_if.i_tlast = 1'b0; e_if.i_tvalid = 1'b1;
    o_if.i_tdata = d; o_if.i_tlast = 1'b0; o_if.i_tvalid = 1'b1;
    tick();
    e_if.i_tvalid = 1'b0; o_if.i_tvalid = 1'b0;
    tick(); tick();
    for (int k = 0; k < f; k++) begin
      tests_run++;
      if (e_tx !== exp_line(d, k / DIV, 1'b1, 1'b1)) begin
        tests_failed++; $display("FAIL parity_even k=%0d: got %b want %b", k, e_tx, exp_line(d, k / DIV, 1'b1, 1'b1));
      end
      tests_run++;
      if (o_tx !== exp_line(d, k / DIV, 1'b1, 1'b0)) begin
        tests_failed++; $display("FAIL parity_odd k=%0d: got %b want %b", k, o_tx, exp_line(d, k / DIV, 1'b1, 1'b0));
      end
      tests_run++;
      if (e_busy !== (k < f - 1)) begin
        tests_failed++; $display("FAIL parity_busy k=%0d: got %b want %b", k, e_busy, (k < f - 1));
      end
      tick();
    end
  endtask

  task automatic test_stop_bits();
    logic [7:0] d0 = 8'hA3;
    logic [7:0] d1 = 8'h3C;
    int f = frame_bits(PARITY_NONE, 2) * DIV;
    logic [7:0] d;
    s_if.i_tdata = d0; s_if.i_tlast = 1'b0; s_if.i_tvalid = 1'b1;
    tick();
    s_if.i_tdata = d1;
    tick();
    s_if.i_tvalid = 1'b0;
    tick();
    for (int k = 0; k < 2 * f; k++) begin
      d = (k < f) ? d0 : d1;
      tests_run++;
      if (s_tx !== exp_line(d, (k % f) / DIV, 1'b0, 1'b0)) begin
        tests_failed++; $display("FAIL stop2_line k=%0d: got %b want %b", k, s_tx, exp_line(d, (k % f) / DIV, 1'b0, 1'b0));
      end
      tests_run++;
      if (s_busy !== (k < 2 * f - 1)) begin
        tests_failed++; $display("FAIL stop2_busy k=%0d: got %b want %b", k, s_busy, (k < 2 * f - 1));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int f = frame_bits(PARITY_NONE, 1) * DIV;
    fork
      begin : driver
        int  idx = 0;
        int  cyc = 0;
        bit  saw_full = 1'b0;
        logic acc;
        while ((idx < 10) && (cyc < 600)) begin
          a_if.i_tvalid = 1'b1;
          a_if.i_tdata  = 8'(idx);
          a_if.i_tlast  = 1'b0;
          acc = a_if.o_tready;
          if (a_level == 3'd4) begin
            saw_full = 1'b1;
            tests_run++;
            if (acc !== 1'b0) begin tests_failed++; $display("FAIL b2b_tready_full cyc=%0d: got %b want 0", cyc, acc); end
          end
          tick();
          if (acc === 1'b1) idx++;
          cyc++;
        end
        a_if.i_tvalid = 1'b0;
        tests_run++; if (idx != 10) begin tests_failed++; $display("FAIL b2b_push_count: got %0d want 10", idx); end
        tests_run++; if (!saw_full) begin tests_failed++; $display("FAIL b2b_reached_full: got 0 want 1"); end
      end
      begin : monitor
        logic [7:0] d;
        tick(); tick(); tick();
        for (int k = 0; k < 10 * f; k++) begin
          d = 8'(k / f);
          tests_run++;
          if (a_tx !== exp_line(d, (k % f) / DIV, 1'b0, 1'b0)) begin
            tests_failed++; $display("FAIL b2b_line k=%0d: got %b want %b", k, a_tx, exp_line(d, (k % f) / DIV, 1'b0, 1'b0));
          end
          tick();
        end
      end
    join
    tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_end: got %b want 0", a_busy); end
    tests_run++; if (a_level !== 3'd0) begin tests_failed++; $display("FAIL b2b_level_end: got %0d want 0", a_level); end
  endtask

  task automatic test_tlast();
    logic [7:0] d;
    bit ok, to;
    for (int pass = 0; pass < 2; pass++) begin
      a_if.i_tdata = 8'h41; a_if.i_tlast = (pass == 0); a_if.i_tvalid = 1'b1;
      tick();
      a_if.i_tvalid = 1'b0; a_if.i_tlast = 1'b0;
      rx_byte(d, ok, to);
      tests_run++; if (to || !ok || (d !== 8'h41)) begin tests_failed++; $display("FAIL tlast_byte pass=%0d: got %h ok=%b to=%b want 41", pass, d, ok, to); end
`ifdef AXIS_UART_TX_EOL_EN
      if (pass == 0) begin
        rx_byte(d, ok, to);
        tests_run++; if (to || !ok || (d !== 8'h0D)) begin tests_failed++; $display("FAIL eol_cr: got %h ok=%b to=%b want 0d", d, ok, to); end
        rx_byte(d, ok, to);
        tests_run++; if (to || !ok || (d !== 8'h0A)) begin tests_failed++; $display("FAIL eol_lf: got %h ok=%b to=%b want 0a", d, ok, to); end
      end
`endif
      for (int k = 0; k < 60; k++) begin
        tests_run++;
        if (a_tx !== 1'b1) begin tests_failed++; $display("FAIL tlast_idle pass=%0d k=%0d: got %b want 1", pass, k, a_tx); end
        tick();
      end
      tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL tlast_busy pass=%0d: got %b want 0", pass, a_busy); end
    end
  endtask

  task automatic test_reset_mid_frame();
    a_if.i_tlast = 1'b0; a_if.i_tvalid = 1'b1;
    a_if.i_tdata = 8'hF0; tick();
    a_if.i_tdata = 8'h11; tick();
    a_if.i_tdata = 8'h22; tick();
    a_if.i_tvalid = 1'b0;
    tests_run++; if (a_tx !== 1'b0) begin tests_failed++; $display("FAIL rstmid_start: got %b want 0", a_tx); end
    tests_run++; if (a_level !== 3'd2) begin tests_failed++; $display("FAIL rstmid_queued: got %0d want 2", a_level); end
    repeat (17) tick();
    tests_run++; if (a_state !== ST_DATA) begin tests_failed++; $display("FAIL rstmid_in_data: got %0d want %0d", a_state, ST_DATA); end
    tests_run++; if (a_tx !== 1'b0) begin tests_failed++; $display("FAIL rstmid_bit3: got %b want 0", a_tx); end
    rst = 1'b1;
    tick();
    tests_run++; if (a_tx !== 1'b1) begin tests_failed++; $display("FAIL rstmid_tx: got %b want 1", a_tx); end
    tests_run++; if (a_level !== 3'd0) begin tests_failed++; $display("FAIL rstmid_level: got %0d want 0", a_level); end
    tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b want 0", a_busy); end
    tests_run++; if (a_state !== ST_IDLE) begin tests_failed++; $display("FAIL rstmid_state: got %0d want %0d", a_state, ST_IDLE); end
    tests_run++; if (a_if.o_tready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_tready_low: got %b want 0", a_if.o_tready); end
    rst = 1'b0;
    tick();
    tests_run++; if (a_if.o_tready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_tready_high: got %b want 1", a_if.o_tready); end
    for (int k = 0; k < 60; k++) begin
      tests_run++;
      if ((a_tx !== 1'b1) || (a_busy !== 1'b0)) begin
        tests_failed++; $display("FAIL rstmid_quiet k=%0d: got tx=%b busy=%b want tx=1 busy=0", k, a_tx, a_busy);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_if.i_tdata = '0; a_if.i_tlast = 1'b0; a_if.i_tvalid = 1'b0;
    e_if.i_tdata = '0; e_if.i_tlast = 1'b0; e_if.i_tvalid = 1'b0;
    o_if.i_tdata = '0; o_if.i_tlast = 1'b0; o_if.i_tvalid = 1'b0;
    s_if.i_tdata = '0; s_if.i_tlast = 1'b0; s_if.i_tvalid = 1'b0;
    tick();
    test_reset();
    test_single_byte();
    test_parity();
    test_stop_bits();
    test_back_to_back();
    test_tlast();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
